rf_cmd_framer: RTL and testbench

RF_CMD_FRAMER -- requirements
Module: rf_cmd_framer

---
 rtl/rf_ctrl_pkg.sv | 44 ++++
 rtl/rf_edge_det.sv | 19 +
 rtl/rf_cmd_framer.sv | 136 +++++++++++++
 tb/tb_rf_cmd_framer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants, frame layout and FSM encoding for the RF command framer.
// Frame on the wire: EB 90 OP B3 B4 B5 B6 CHK, CHK = 8-bit sum of OP..B6.
package rf_ctrl_pkg;

  localparam logic [7:0] SYNC_B0   = 8'hEB;
  localparam logic [7:0] SYNC_B1   = 8'h90;
  localparam logic [7:0] OP_SET    = 8'h01;
  localparam logic [7:0] OP_QUERY  = 8'h02;
  localparam int         FRAME_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] b3;
    logic [7:0] b4;
    logic [7:0] b5;
    logic [7:0] b6;
  } frame_t;

  function automatic logic [7:0] frame_chk(input frame_t f);
    return f.op + f.b3 + f.b4 + f.b5 + f.b6;
  endfunction

  function automatic logic [7:0] frame_byte(input frame_t f, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_B0;
      3'd1:    b = SYNC_B1;
      3'd2:    b = f.op;
      3'd3:    b = f.b3;
      3'd4:    b = f.b4;
      3'd5:    b = f.b5;
      3'd6:    b = f.b6;
      default: b = frame_chk(f);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rf_edge_det.sv
// Rising-edge detector for a GPIO level; combinational pulse, one cycle wide.
// History register resets to 1 so a level already high at reset is not an event.
module rf_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b1;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/rf_cmd_framer.sv
// Turns GPIO SET/QUERY requests into 8-byte UART frames with RS-485 enable and gap.
// First byte two cycles after the request edge; bytes hold under i_byte_rdy stalls.
module rf_cmd_framer
  import rf_ctrl_pkg::*;
#(
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_rf_data,
  input  logic [31:0] i_up_gain,
  input  logic [31:0] i_down_gain,
  input  logic        i_rf_data_vld,
  input  logic        i_rf_ask_flag,
  output logic [7:0]  o_byte,
  output logic        o_byte_vld,
  input  logic        i_byte_rdy,
  output logic        o_tx_ctrl,
  output logic [31:0] o_send_num
);

  state_t      state, state_nxt;
  frame_t      cur, cur_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic [7:0]  byte_nxt;
  logic        vld_nxt, txc_nxt;
  logic [31:0] num_nxt;
  logic        rise_set, rise_qry;
  logic        pend_set, pend_qry;
  logic        start, launch_set;
  logic [15:0] snap_freq;
  logic [7:0]  snap_up, snap_down;
  logic        unused_bits;

  assign unused_bits = ^{i_rf_data[31:16], i_up_gain[31:8], i_down_gain[31:8]};

  rf_edge_det u_set_edge (.clk(clk), .rst(rst), .din(i_rf_data_vld), .rise(rise_set));
  rf_edge_det u_qry_edge (.clk(clk), .rst(rst), .din(i_rf_ask_flag), .rise(rise_qry));

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    idx_nxt    = idx;
    gap_nxt    = gap_cnt;
    byte_nxt   = o_byte;
    vld_nxt    = o_byte_vld;
    num_nxt    = o_send_num;
    start      = 1'b0;
    launch_set = 1'b0;
    case (state)
      ST_IDLE: start = pend_set | pend_qry;
      ST_SEND: begin
        if (o_byte_vld && i_byte_rdy) begin
          if (idx == 3'(FRAME_LEN - 1)) begin
            state_nxt = ST_GAP;
            vld_nxt   = 1'b0;
            gap_nxt   = '0;
            num_nxt   = o_send_num + 32'd1;
          end else begin
            idx_nxt  = idx + 3'd1;
            byte_nxt = frame_byte(cur, idx + 3'd1);
          end
        end
      end
      ST_GAP: begin
        // Last gap cycle doubles as an idle decision so a queued frame follows directly.
        if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
          start     = pend_set | pend_qry;
        end else begin
          gap_nxt = gap_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (start) begin
      launch_set = pend_set;
      if (pend_set) begin
        cur_nxt.op = OP_SET;
        cur_nxt.b3 = snap_freq[15:8];
        cur_nxt.b4 = snap_freq[7:0];
        cur_nxt.b5 = snap_up;
        cur_nxt.b6 = snap_down;
      end else begin
        cur_nxt.op = OP_QUERY;
        cur_nxt.b3 = 8'h00;
        cur_nxt.b4 = 8'h00;
        cur_nxt.b5 = 8'h00;
        cur_nxt.b6 = 8'h00;
      end
      state_nxt = ST_SEND;
      idx_nxt   = '0;
      byte_nxt  = SYNC_B0;
      vld_nxt   = 1'b1;
    end
    txc_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur        <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      o_byte     <= 8'h00;
      o_byte_vld <= 1'b0;
      o_tx_ctrl  <= 1'b0;
      o_send_num <= '0;
      pend_set   <= 1'b0;
      pend_qry   <= 1'b0;
      snap_freq  <= '0;
      snap_up    <= '0;
      snap_down  <= '0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      idx        <= idx_nxt;
      gap_cnt    <= gap_nxt;
      o_byte     <= byte_nxt;
      o_byte_vld <= vld_nxt;
      o_tx_ctrl  <= txc_nxt;
      o_send_num <= num_nxt;
      // A new edge in the launch cycle stays pending for the next frame.
      pend_set   <= rise_set | (pend_set & ~launch_set);
      pend_qry   <= rise_qry | (pend_qry & ~(start & ~pend_set));
      if (rise_set) begin
        snap_freq <= i_rf_data[15:0];
        snap_up   <= i_up_gain[7:0];
        snap_down <= i_down_gain[7:0];
      end
    end
  end

endmodule

// File: tb/tb_rf_cmd_framer.sv
// Self-checking bench for rf_cmd_framer: table of frames plus hand sequences,
// with a byte scoreboard fed at stimulus time and drained on each transfer.
module tb_rf_cmd_framer;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_rf_data, i_up_gain, i_down_gain;
  logic        i_rf_data_vld, i_rf_ask_flag;
  logic [7:0]  o_byte;
  logic        o_byte_vld;
  logic        i_byte_rdy;
  logic        o_tx_ctrl;
  logic [31:0] o_send_num;

  always #5 clk = ~clk;

  rf_cmd_framer #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .i_rf_data(i_rf_data), .i_up_gain(i_up_gain), .i_down_gain(i_down_gain),
    .i_rf_data_vld(i_rf_data_vld), .i_rf_ask_flag(i_rf_ask_flag),
    .o_byte(o_byte), .o_byte_vld(o_byte_vld), .i_byte_rdy(i_byte_rdy),
    .o_tx_ctrl(o_tx_ctrl), .o_send_num(o_send_num)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  logic [7:0] sb[$];
  int rdy_mode = 0;
  int xfer_cnt = 0, last_xfer_cyc = 0, vld_rise_cyc = 0;
  int tx_rise_cyc = 0, tx_fall_cyc = 0, num_chg_cyc = 0;
  logic prev_vld = 1'b0, prev_tx = 1'b0, prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  logic [31:0] prev_num = 32'h0;
  logic [7:0]  exp_b;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_vld_held", 32'(o_byte_vld), 32'd1);
      chk("stall_byte_stable", 32'(o_byte), 32'(prev_byte));
    end
    if (o_byte_vld && !prev_vld) vld_rise_cyc = cyc;
    if (o_tx_ctrl && !prev_tx)   tx_rise_cyc  = cyc;
    if (!o_tx_ctrl && prev_tx)   tx_fall_cyc  = cyc;
    if (o_send_num != prev_num)  num_chg_cyc  = cyc;
    if (o_byte_vld && i_byte_rdy && !rst) begin
      chk("xfer_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        chk("frame_byte", 32'(o_byte), 32'(exp_b));
      end
      xfer_cnt++;
      last_xfer_cyc = cyc;
    end
    prev_vld   = o_byte_vld;
    prev_tx    = o_tx_ctrl;
    prev_num   = o_send_num;
    prev_byte  = o_byte;
    prev_stall = o_byte_vld && !i_byte_rdy && !rst;
  end

  initial begin
    i_byte_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_byte_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b0;
    end
  end

  typedef struct {
    logic        is_set;
    logic [15:0] freq;
    logic [7:0]  up;
    logic [7:0]  down;
    int          mode;
    logic [63:0] frame;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [63:0] f);
    for (int b = 7; b >= 0; b--) sb.push_back(f[b*8 +: 8]);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("xfers_reached", 32'(xfer_cnt), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_tx_ctrl && n < budget) begin
      tick();
      n++;
    end
    chk("tx_ctrl_released", 32'(o_tx_ctrl), 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rf_data_vld = 1'b0;
    i_rf_ask_flag = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_data(input logic [15:0] f, input logic [7:0] u, input logic [7:0] d);
    i_rf_data   = {16'hDEAD, f};
    i_up_gain   = {24'hA5A5A5, u};
    i_down_gain = {24'h5A5A5A, d};
  endtask

  int edge_cyc, base, exp_num, set_last;

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 8'h05, 8'h0A, 0, 64'hEB90_0112_3405_0A56};
    vecs[1] = '{1'b0, 16'h0000, 8'h00, 8'h00, 0, 64'hEB90_0200_0000_0002};
    vecs[2] = '{1'b1, 16'h1234, 8'h05, 8'h0A, 1, 64'hEB90_0112_3405_0A56};
    vecs[3] = '{1'b1, 16'hABCD, 8'hFF, 8'h80, 0, 64'hEB90_01AB_CDFF_80F8};
    vecs[4] = '{1'b1, 16'hFFFF, 8'hFF, 8'hFF, 1, 64'hEB90_01FF_FFFF_FFFD};
    vecs[5] = '{1'b0, 16'h0000, 8'h00, 8'h00, 1, 64'hEB90_0200_0000_0002};

    // Reset with the query level held high: no event may follow release.
    rst = 1'b1;
    i_rf_data_vld = 1'b0;
    i_rf_ask_flag = 1'b1;
    set_data(16'h0, 8'h0, 8'h0);
    tick(); tick(); tick();
    chk("rst_byte", 32'(o_byte), 32'h00);
    chk("rst_vld", 32'(o_byte_vld), 32'd0);
    chk("rst_tx_ctrl", 32'(o_tx_ctrl), 32'd0);
    chk("rst_send_num", o_send_num, 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    chk("held_high_no_event", 32'(o_tx_ctrl), 32'd0);
    i_rf_ask_flag = 1'b0;
    repeat (3) tick();

    exp_num = 0;
    for (int i = 0; i < 6; i++) begin
      rdy_mode = vecs[i].mode;
      set_data(vecs[i].freq, vecs[i].up, vecs[i].down);
      base = xfer_cnt;
      push_frame(vecs[i].frame);
      tick();
      if (vecs[i].is_set) i_rf_data_vld = 1'b1;
      else                i_rf_ask_flag = 1'b1;
      edge_cyc = cyc;
      tick(); tick();
      i_rf_data_vld = 1'b0;
      i_rf_ask_flag = 1'b0;
      wait_xfers(base + 8, 200);
      wait_idle(100);
      exp_num++;
      chk("first_byte_latency", 32'(vld_rise_cyc - edge_cyc), 32'd2);
      chk("tx_rise_latency", 32'(tx_rise_cyc - edge_cyc), 32'd2);
      chk("send_num_step_cycle", 32'(num_chg_cyc - last_xfer_cyc), 32'd1);
      chk("tx_low_after_last", 32'(tx_fall_cyc - last_xfer_cyc), 32'(GAP + 1));
      chk("send_num", o_send_num, 32'(exp_num));
      chk("sb_drained", 32'(sb.size()), 32'd0);
    end

    // SET and QUERY edges together: SET frame, then QUERY right after the gap.
    rdy_mode = 0;
    do_reset();
    set_data(16'h0102, 8'h03, 8'h04);
    base = xfer_cnt;
    push_frame(64'hEB90_0101_0203_040B);
    push_frame(64'hEB90_0200_0000_0002);
    tick();
    i_rf_data_vld = 1'b1;
    i_rf_ask_flag = 1'b1;
    tick(); tick();
    i_rf_data_vld = 1'b0;
    i_rf_ask_flag = 1'b0;
    wait_xfers(base + 8, 200);
    set_last = last_xfer_cyc;
    wait_xfers(base + 16, 200);
    wait_idle(100);
    chk("query_after_gap", 32'(vld_rise_cyc - set_last), 32'(GAP + 1));
    chk("both_send_num", o_send_num, 32'd2);
    chk("both_sb_drained", 32'(sb.size()), 32'd0);

    // Two SET edges during a slow frame merge into one frame with the latest snapshot.
    do_reset();
    rdy_mode = 1;
    set_data(16'h00FF, 8'h00, 8'h00);
    base = xfer_cnt;
    push_frame(64'hEB90_0100_FF00_0000);
    tick();
    i_rf_data_vld = 1'b1;
    tick(); tick();
    i_rf_data_vld = 1'b0;
    wait_xfers(base + 1, 50);
    set_data(16'h0001, 8'h00, 8'h00);
    tick();
    i_rf_data_vld = 1'b1;
    tick(); tick();
    i_rf_data_vld = 1'b0;
    set_data(16'h0002, 8'h00, 8'h00);
    tick();
    i_rf_data_vld = 1'b1;
    tick(); tick();
    i_rf_data_vld = 1'b0;
    push_frame(64'hEB90_0100_0200_0003);
    wait_xfers(base + 16, 300);
    wait_idle(100);
    repeat (40) tick();
    chk("merged_no_extra_frame", 32'(xfer_cnt), 32'(base + 16));
    chk("merged_send_num", o_send_num, 32'd2);
    chk("merged_sb_drained", 32'(sb.size()), 32'd0);

    // Reset after the third byte with the SET level held high.
    do_reset();
    rdy_mode = 0;
    set_data(16'h1234, 8'h05, 8'h0A);
    base = xfer_cnt;
    sb.push_back(8'hEB);
    sb.push_back(8'h90);
    sb.push_back(8'h01);
    tick();
    i_rf_data_vld = 1'b1;
    wait_xfers(base + 3, 50);
    rst = 1'b1;
    rdy_mode = 2;
    i_byte_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    rdy_mode = 0;
    repeat (40) tick();
    chk("abort_no_more_bytes", 32'(xfer_cnt), 32'(base + 3));
    chk("abort_send_num", o_send_num, 32'd0);
    chk("abort_tx_ctrl", 32'(o_tx_ctrl), 32'd0);
    chk("abort_vld", 32'(o_byte_vld), 32'd0);
    chk("abort_byte", 32'(o_byte), 32'h00);
    chk("abort_sb_drained", 32'(sb.size()), 32'd0);
    i_rf_data_vld = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
